router_pkt_reg_p: RTL and testbench
===================================

// Module: router_pkt_reg_p
// PURPOSE
//  Parametrised packet input register for the router. It takes packets from the source port and
//  captures the header and destination. It accumulates a running XOR or modular-sum checksum over
//  header and payload, and compares that against the trailing check byte.
//  All bytes pass through an internal skid buffer toward the destination FIFO; fifo_full is
//  absorbed there, and busy is raised back to the source only when the buffer fills.
// PARAMETERS
//  DATA_WIDTH  8  width of data_in/dout and of the checksum
//  ADDR_BITS   2  header[ADDR_BITS-1:0] = destination port
//  SKID_DEPTH  4  skid buffer entries; legal range >= 2
//  CHECK_MODE  0  0 = XOR parity, 1 = sum modulo 2^DATA_WIDTH
// PORTS
//  clock      in   1           rising-edge clock
//  resetn     in   1           synchronous, active-low reset
//  pkt_valid  in   1           source: high for header+payload, low while the check byte is presented
//  data_in    in   DATA_WIDTH  source byte; held stable while busy=1
//  busy       out  1           source must not advance (combinational)
//  fifo_full  in   1           selected destination FIFO cannot take a write this cycle
//  dout       out  DATA_WIDTH  byte to destination FIFO (registered)
//  write_enb  out  1           dout valid, write this cycle (registered)
//  dest       out  ADDR_BITS   destination of current packet (registered)
//  hdr_valid  out  1           one-cycle pulse: new header captured, dest updated
//  parity_done out 1           one-cycle pulse: check complete, err valid
//  err        out  1           check mismatch of last completed packet
// BEHAVIOUR
//  Reset: state=IDLE, skid emptied (buffered bytes dropped), checksum=0.
//   All outputs 0, except busy: 0 (IDLE).
//   Reset overrides any packet in flight.
//  Byte accepted at a clock edge when the state's accept condition holds and busy=0.
//   Every accepted byte is pushed to the skid, including header and check byte.
//  FSM:
//   IDLE  : busy=0.
//           Accept when pkt_valid=1 (header): checksum<=data_in, dest<=data_in[ADDR_BITS-1:0],
//           hdr_valid<=1, err<=0 -> LOAD.
//   LOAD  : busy=(count==SKID_DEPTH).
//           pkt_valid=1 & !busy: payload, checksum<=checksum op data_in.
//           pkt_valid=0 & !busy: check byte, chk_byte<=data_in, checksum unchanged -> CHECK.
//   CHECK : busy=1 for exactly one cycle.
//           At exit: err<=(checksum!=chk_byte), parity_done<=1 -> DRAIN if count>0 after this edge, else IDLE.
//   DRAIN : busy=1. -> IDLE on the edge where count becomes 0.
//  Checksum op: XOR (CHECK_MODE=0) or add with carry discarded (CHECK_MODE=1).
//  Output stage, per edge: if count>0 and fifo_full=0, pop head to dout with write_enb<=1; else write_enb<=0.
//   dout holds its last value when not writing.
//   Push and pop may occur on the same edge; count unchanged.
//  Latency: a byte accepted at edge E with empty skid and fifo_full=0 at E+1 is on dout/write_enb after E+1.
//  fifo_full held high: skid fills; busy rises once count==SKID_DEPTH.
//   A simultaneous pop does not lower busy in that cycle.
//   No byte is lost or duplicated; FIFO order is preserved.
//  A header cannot be accepted until the previous packet is fully drained (back-to-back gap >= 2 cycles).
//  Header with payload length 0 (pkt_valid low the cycle after header) is legal:
//   checksum = header only.
//  err persists until the next header is accepted.
//  hdr_valid and parity_done are never high for more than one consecutive cycle.
// TESTING
//  T1 XOR: CHECK_MODE=0, hdr 8'h41, payload 8'h11,8'h22, check 8'h72, fifo_full=0
//     -> dest=1, dout sequence 41,11,22,72, parity_done pulse, err=0.
//  T2 SUM: CHECK_MODE=1, same hdr/payload, check 8'h74 -> err=0.
//     Check 8'h72 in this mode -> err=1 after parity_done, cleared on next header.
//  T3 backpressure: SKID_DEPTH=4, fifo_full=1 from header for 10 cycles, 6 payload bytes
//     -> busy=1 after 4 accepts, data_in held; on release all 8 bytes out in order, no gaps.
//  T4 zero-length: hdr 8'h03 then pkt_valid=0 with check 8'h03 -> dest=3, dout 03,03, err=0.
//  T5 reset mid-packet: resetn=0 for 1 cycle after 2 payload bytes with fifo_full=1
//     -> write_enb=0, busy=0, err=0, skid empty.
//     Next packet checks correctly.
//  T6 back-to-back packets, alternating fifo_full every cycle
//     -> hdr_valid/parity_done each one cycle per packet, write_enb count = total bytes.

Source files
------------

// File: rtl/router_pkt_reg_p.sv
// -----------------------------------------------------------------------------
// router_pkt_reg_p
//
// Packet input register for the router. It takes one packet at a time from the
// source port. A packet is a header byte and zero or more payload bytes, all
// sent with pkt_valid high. They are followed by a check byte sent with
// pkt_valid low.
//
// What it does with each packet:
//   * The header's low ADDR_BITS bits are latched as the destination port.
//   * A running checksum is kept over the header and payload. It is either an
//     XOR or a sum modulo 2^DATA_WIDTH. At the end it is compared against the
//     check byte.
//   * Every accepted byte, including the header and the check byte, goes
//     through a small skid buffer toward the destination FIFO. fifo_full
//     backpressure is absorbed there. busy is raised to the source only once
//     the buffer is full, during the one-cycle check, and while the packet
//     drains.
//
// Ports
//   clock        rising-edge clock
//   resetn       synchronous, active-low reset
//   pkt_valid    source: high for header and payload, low with the check byte
//   data_in      source byte; held stable by the source while busy is high
//   busy         source must not advance (combinational from state/count)
//   fifo_full    destination FIFO cannot take a write this cycle
//   dout         byte to the destination FIFO (registered)
//   write_enb    dout is valid and written this cycle (registered)
//   dest         destination port of the current packet (registered)
//   hdr_valid    one-cycle pulse: header captured, dest updated
//   parity_done  one-cycle pulse: check complete, err valid
//   err          checksum mismatch of the last completed packet
//
// SKID_DEPTH must be at least 2.
// -----------------------------------------------------------------------------
module router_pkt_reg_p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 2,
    parameter int unsigned SKID_DEPTH = 4,
    parameter int unsigned CHECK_MODE = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  write_enb,
    output logic [ADDR_BITS-1:0]  dest,
    output logic                  hdr_valid,
    output logic                  parity_done,
    output logic                  err
);

    // -------------------------------------------------------------------------
    // Local sizing
    // -------------------------------------------------------------------------
    localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SKID_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic [DATA_WIDTH-1:0] chk_byte_q, chk_byte_d;
    logic [ADDR_BITS-1:0]  dest_q, dest_d;
    logic                  err_q, err_d;
    logic                  hdr_valid_q, hdr_valid_d;
    logic                  parity_done_q, parity_done_d;

    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [DATA_WIDTH-1:0] dout_q;
    logic                  write_enb_q;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic skid_full;
    logic busy_c;
    logic accept;
    logic push;
    logic pop;

    assign skid_full = (count_q == CNT_FULL);

    // busy depends only on registered state and count, never on the inputs.
    // A pop on the same edge therefore cannot lower it within that cycle.
    always_comb begin
        busy_c = 1'b1;
        case (state_q)
            ST_IDLE:  busy_c = 1'b0;
            ST_LOAD:  busy_c = skid_full;
            ST_CHECK: busy_c = 1'b1;
            ST_DRAIN: busy_c = 1'b1;
            default:  busy_c = 1'b1;
        endcase
    end

    assign busy = busy_c;

    // In IDLE only a header (pkt_valid high) is taken. In LOAD every
    // presented byte is taken: payload or check byte.
    assign accept = !busy_c &&
                    (((state_q == ST_IDLE) && pkt_valid) || (state_q == ST_LOAD));
    assign push   = accept;
    assign pop    = (count_q != '0) && !fifo_full;

    // -------------------------------------------------------------------------
    // Checksum operator
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] csum_upd;

    generate
        if (CHECK_MODE == 0) begin : g_xor
            assign csum_upd = checksum_q ^ data_in;
        end else begin : g_sum
            // The carry out of the top bit is dropped, giving a sum modulo 2^DATA_WIDTH.
            assign csum_upd = checksum_q + data_in;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Skid pointers and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Packet FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        checksum_d    = checksum_q;
        chk_byte_d    = chk_byte_q;
        dest_d        = dest_q;
        err_d         = err_q;
        hdr_valid_d   = 1'b0;
        parity_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // The header seeds the checksum. It also clears the
                    // previous packet's error flag.
                    checksum_d  = data_in;
                    dest_d      = data_in[ADDR_BITS-1:0];
                    hdr_valid_d = 1'b1;
                    err_d       = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    if (pkt_valid) begin
                        checksum_d = csum_upd;
                    end else begin
                        // The check byte is not folded into the checksum.
                        chk_byte_d = data_in;
                        state_d    = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                err_d         = (checksum_q != chk_byte_q);
                parity_done_d = 1'b1;
                // Nothing is pushed in CHECK, so count_d reflects pops only.
                state_d       = (count_d != '0) ? ST_DRAIN : ST_IDLE;
            end

            ST_DRAIN: begin
                // A new header must wait until the whole packet has left the skid.
                if (count_d == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Skid storage: array with a single write port and a registered read port.
    // No reset is needed; occupancy is tracked by the pointers and count.
    // A write and a read never hit the same entry on one edge: a pop needs
    // count > 0 and a push needs count < SKID_DEPTH.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            skid_mem[wr_ptr_q] <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            checksum_q    <= '0;
            chk_byte_q    <= '0;
            dest_q        <= '0;
            err_q         <= 1'b0;
            hdr_valid_q   <= 1'b0;
            parity_done_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dout_q        <= '0;
            write_enb_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            checksum_q    <= checksum_d;
            chk_byte_q    <= chk_byte_d;
            dest_q        <= dest_d;
            err_q         <= err_d;
            hdr_valid_q   <= hdr_valid_d;
            parity_done_q <= parity_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            write_enb_q   <= pop;
            // dout keeps its last value on cycles without a write.
            if (pop) begin
                dout_q <= skid_mem[rd_ptr_q];
            end
        end
    end

    assign dout        = dout_q;
    assign write_enb   = write_enb_q;
    assign dest        = dest_q;
    assign hdr_valid   = hdr_valid_q;
    assign parity_done = parity_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_router_pkt_reg_p.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_reg_p
//
// Two instances of router_pkt_reg_p are driven from the same inputs. One uses
// XOR checksums and the other uses modulo sums. A transaction-level model
// predicts the outputs of both every cycle:
//   * a queue holds the bytes in the skid;
//   * a packet phase tracks where the packet is;
//   * running XOR and sum values are kept separately.
// The source side uses the model's busy, not the DUT's, to decide when a byte
// was taken.
// -----------------------------------------------------------------------------
module tb_router_pkt_reg_p;

    localparam int DW = 8;
    localparam int AB = 2;
    localparam int SD = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [DW-1:0] data_in;
    logic          fifo_full;

    logic          x_busy, x_we, x_hv, x_pd, x_err;
    logic [DW-1:0] x_dout;
    logic [AB-1:0] x_dest;
    logic          s_busy, s_we, s_hv, s_pd, s_err;
    logic [DW-1:0] s_dout;
    logic [AB-1:0] s_dest;

    always #5 clock = ~clock;

    router_pkt_reg_p #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .SKID_DEPTH(SD), .CHECK_MODE(0)) u_xor (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .busy(x_busy), .fifo_full(fifo_full), .dout(x_dout), .write_enb(x_we),
        .dest(x_dest), .hdr_valid(x_hv), .parity_done(x_pd), .err(x_err)
    );

    router_pkt_reg_p #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .SKID_DEPTH(SD), .CHECK_MODE(1)) u_sum (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .busy(s_busy), .fifo_full(fifo_full), .dout(s_dout), .write_enb(s_we),
        .dest(s_dest), .hdr_valid(s_hv), .parity_done(s_pd), .err(s_err)
    );

    // ---------------- reference model ----------------
    int            m_phase;   // 0 idle, 1 receiving, 2 checking, 3 draining
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_xsum, m_ssum, m_chk, m_dout;
    logic [AB-1:0] m_dest;
    logic          m_we, m_hv, m_pd, m_xerr, m_serr;
    bit            m_valid = 1'b0;

    // ---------------- bookkeeping ----------------
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            ff_mode = 0;
    int            ff_until = 0;
    int            n_hv = 0, n_pd = 0, n_we = 0;
    logic [DW-1:0] out_log[$];
    int            we_cyc[$];
    logic [DW-1:0] pl_q[$];

    function automatic bit model_busy();
        return (m_phase == 1 && m_q.size() == SD) || m_phase == 2 || m_phase == 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s observed=timeout expected=progress", tag);
    endtask

    // One clock cycle: drive fifo_full, check busy, step the model on the
    // edge, then check the registered outputs.
    task automatic tick(output bit acc);
        bit pop;
        case (ff_mode)
            0:       fifo_full = 1'b0;
            1:       fifo_full = 1'b1;
            2:       fifo_full = ((cyc % 2) == 1);
            3:       fifo_full = ($urandom_range(0, 1) == 1);
            default: fifo_full = (cyc < ff_until);
        endcase
        #1;
        if (m_valid) begin
            check("busy_x", {31'd0, x_busy}, {31'd0, model_busy()});
            check("busy_s", {31'd0, s_busy}, {31'd0, model_busy()});
        end
        acc = resetn && !model_busy() && ((m_phase == 0 && pkt_valid) || m_phase == 1);
        @(posedge clock);
        cyc++;
        if (!resetn) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_q.delete();
            m_xsum = '0; m_ssum = '0; m_chk = '0; m_dout = '0; m_dest = '0;
            m_we = 1'b0; m_hv = 1'b0; m_pd = 1'b0; m_xerr = 1'b0; m_serr = 1'b0;
        end else begin
            m_hv = 1'b0;
            m_pd = 1'b0;
            pop  = (m_q.size() > 0) && !fifo_full;
            if (pop) begin
                m_dout = m_q.pop_front();
                m_we   = 1'b1;
            end else begin
                m_we   = 1'b0;
            end
            if (acc) m_q.push_back(data_in);
            case (m_phase)
                0: if (acc) begin
                    m_xsum = data_in; m_ssum = data_in; m_dest = data_in[AB-1:0];
                    m_hv = 1'b1; m_xerr = 1'b0; m_serr = 1'b0; m_phase = 1;
                end
                1: if (acc) begin
                    if (pkt_valid) begin
                        m_xsum = m_xsum ^ data_in;
                        m_ssum = m_ssum + data_in;
                    end else begin
                        m_chk = data_in;
                        m_phase = 2;
                    end
                end
                2: begin
                    m_xerr = (m_xsum != m_chk);
                    m_serr = (m_ssum != m_chk);
                    m_pd = 1'b1;
                    m_phase = (m_q.size() > 0) ? 3 : 0;
                end
                default: if (m_q.size() == 0) m_phase = 0;
            endcase
        end
        #1;
        if (m_valid) begin
            check("dout_x", {24'd0, x_dout}, {24'd0, m_dout});
            check("dout_s", {24'd0, s_dout}, {24'd0, m_dout});
            check("we_x", {31'd0, x_we}, {31'd0, m_we});
            check("we_s", {31'd0, s_we}, {31'd0, m_we});
            check("dest_x", {30'd0, x_dest}, {30'd0, m_dest});
            check("dest_s", {30'd0, s_dest}, {30'd0, m_dest});
            check("hv_x", {31'd0, x_hv}, {31'd0, m_hv});
            check("hv_s", {31'd0, s_hv}, {31'd0, m_hv});
            check("pd_x", {31'd0, x_pd}, {31'd0, m_pd});
            check("pd_s", {31'd0, s_pd}, {31'd0, m_pd});
            check("err_x", {31'd0, x_err}, {31'd0, m_xerr});
            check("err_s", {31'd0, s_err}, {31'd0, m_serr});
        end
        if (x_we === 1'b1) begin
            out_log.push_back(x_dout);
            we_cyc.push_back(cyc);
            n_we++;
        end
        if (x_hv === 1'b1) n_hv++;
        if (x_pd === 1'b1) n_pd++;
    endtask

    task automatic send_byte(input logic pv, input logic [DW-1:0] d);
        bit acc;
        pkt_valid = pv;
        data_in   = d;
        for (int n = 0; n < 100; n++) begin
            tick(acc);
            if (acc) return;
        end
        fail_timeout("send_byte");
    endtask

    task automatic drain();
        bit acc;
        pkt_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (m_phase == 0 && m_q.size() == 0) return;
            data_in = 8'($urandom_range(0, 255));
            tick(acc);
        end
        fail_timeout("drain");
    endtask

    task automatic send_packet(input logic [DW-1:0] hdr, input logic [DW-1:0] chk);
        send_byte(1'b1, hdr);
        foreach (pl_q[i]) send_byte(1'b1, pl_q[i]);
        send_byte(1'b0, chk);
        drain();
    endtask

    function automatic logic [DW-1:0] xor_of(input logic [DW-1:0] hdr);
        logic [DW-1:0] r = hdr;
        foreach (pl_q[i]) r = r ^ pl_q[i];
        return r;
    endfunction

    // Compares the logged output stream with header, payload and check byte, in order.
    task automatic check_stream(input string tag, input logic [DW-1:0] hdr, input logic [DW-1:0] chk);
        logic [DW-1:0] e[$];
        e.push_back(hdr);
        foreach (pl_q[i]) e.push_back(pl_q[i]);
        e.push_back(chk);
        check({tag, "_len"}, out_log.size(), e.size());
        foreach (e[i]) begin
            if (i < out_log.size()) check({tag, "_byte"}, {24'd0, out_log[i]}, {24'd0, e[i]});
        end
    endtask

    initial begin
        bit acc;
        int pkts, bytes;
        logic [DW-1:0] hdr, chk;

        // ---- reset ----
        resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; ff_mode = 0;
        tick(acc);
        tick(acc);
        resetn = 1'b1;
        tick(acc);
        check("rst_we", {31'd0, x_we}, 32'd0);
        check("rst_busy", {31'd0, x_busy}, 32'd0);
        check("rst_err", {31'd0, x_err}, 32'd0);
        check("rst_dout", {24'd0, x_dout}, 32'd0);

        // ---- T1 / T2: XOR and SUM checks ----
        out_log.delete(); we_cyc.delete();
        pl_q = '{8'h11, 8'h22};
        send_packet(8'h41, 8'h72);
        check_stream("t1", 8'h41, 8'h72);
        check("t1_dest", {30'd0, x_dest}, 32'd1);
        check("t1_err_x", {31'd0, x_err}, 32'd0);
        check("t1_err_s", {31'd0, s_err}, 32'd1);
        send_packet(8'h41, 8'h74);
        check("t2_err_s", {31'd0, s_err}, 32'd0);
        check("t2_err_x", {31'd0, x_err}, 32'd1);
        send_packet(8'h41, 8'h72);
        check("t2_err_s_bad", {31'd0, s_err}, 32'd1);
        pl_q.delete();
        send_byte(1'b1, 8'h02);
        check("t2_err_clr", {31'd0, s_err}, 32'd0);
        send_byte(1'b0, 8'h02);
        drain();

        // ---- T3: backpressure ----
        out_log.delete(); we_cyc.delete();
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        ff_mode = 4;
        ff_until = cyc + 10;
        send_byte(1'b1, 8'h42);
        for (int i = 0; i < 3; i++) send_byte(1'b1, pl_q[i]);
        #1;
        check("t3_busy_full", {31'd0, x_busy}, 32'd1);
        for (int i = 3; i < 6; i++) send_byte(1'b1, pl_q[i]);
        chk = xor_of(8'h42);
        send_byte(1'b0, chk);
        drain();
        check_stream("t3", 8'h42, chk);
        if (we_cyc.size() == 8) check("t3_nogap", we_cyc[7] - we_cyc[0], 32'd7);
        check("t3_err", {31'd0, x_err}, 32'd0);
        ff_mode = 0;

        // ---- T4: zero-length packet ----
        out_log.delete(); we_cyc.delete();
        pl_q.delete();
        send_packet(8'h03, 8'h03);
        check_stream("t4", 8'h03, 8'h03);
        check("t4_dest", {30'd0, x_dest}, 32'd3);
        check("t4_err_x", {31'd0, x_err}, 32'd0);
        check("t4_err_s", {31'd0, s_err}, 32'd0);

        // ---- T5: reset mid-packet ----
        ff_mode = 1;
        send_byte(1'b1, 8'h81);
        send_byte(1'b1, 8'h55);
        send_byte(1'b1, 8'h66);
        resetn = 1'b0;
        tick(acc);
        resetn = 1'b1;
        ff_mode = 0;
        check("t5_we", {31'd0, x_we}, 32'd0);
        check("t5_err", {31'd0, x_err}, 32'd0);
        #1;
        check("t5_busy", {31'd0, x_busy}, 32'd0);
        out_log.delete(); we_cyc.delete();
        pl_q = '{8'hA5};
        send_packet(8'h12, xor_of(8'h12));
        check_stream("t5", 8'h12, xor_of(8'h12));
        check("t5_err_after", {31'd0, x_err}, 32'd0);

        // ---- T6: back-to-back, alternating fifo_full ----
        ff_mode = 2;
        n_hv = 0; n_pd = 0; n_we = 0; bytes = 0;
        for (int p = 0; p < 5; p++) begin
            pl_q.delete();
            for (int k = 0; k < p; k++) pl_q.push_back(8'($urandom_range(0, 255)));
            hdr = 8'($urandom_range(0, 255));
            send_packet(hdr, xor_of(hdr));
            bytes += p + 2;
        end
        check("t6_hv_count", n_hv, 32'd5);
        check("t6_pd_count", n_pd, 32'd5);
        check("t6_we_count", n_we, bytes);

        // ---- random packets, random fifo_full ----
        ff_mode = 3;
        pkts = 0;
        for (int p = 0; p < 25; p++) begin
            pl_q.delete();
            for (int k = 0; k < $urandom_range(0, 7); k++) pl_q.push_back(8'($urandom_range(0, 255)));
            hdr = 8'($urandom_range(0, 255));
            chk = ($urandom_range(0, 1) == 1) ? xor_of(hdr) : 8'($urandom_range(0, 255));
            out_log.delete(); we_cyc.delete();
            send_packet(hdr, chk);
            check_stream("rnd", hdr, chk);
            pkts++;
        end
        check("rnd_pkts", pkts, 32'd25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
